shift_tick_gen: RTL and testbench

Strobe generator that drives the `i_valid` advance input of the LED rotation shift register, which consumes the strobe.
- Continuous mode: prescaler counter emits 1-cycle `o_valid` pulses at one of four switch-selected periods.
- Step mode: while continuous mode is disabled, each rising edge of a step request emits exactly one pulse.
- Sits between board switches/buttons and the shift register.

---
 rtl/shift_tick_pkg.sv | 17 +
 rtl/edge_rise.sv | 19 +
 rtl/shift_tick_gen.sv | 81 ++++++++
 tb/tb_shift_tick_gen.sv | 128 ++++++++++++
 4 files changed

// File: rtl/shift_tick_pkg.sv
// shift_tick_pkg: shared state encoding, default widths and rate-select lookup
// for the LED rotation strobe generator.
package shift_tick_pkg;

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_e;

    localparam int NB_SEL_DEF     = 2;
    localparam int NB_COUNTER_DEF = 32;

    // Limits are 64 bits wide so a period of exactly 2**NB_COUNTER can be expressed.
    function automatic logic [63:0] sel_to_limit(input logic [1:0] sel, input logic [63:0] l0,
                                                 input logic [63:0] l1, input logic [63:0] l2,
                                                 input logic [63:0] l3);
        return sel == 2'd0 ? l0 : sel == 2'd1 ? l1 : sel == 2'd2 ? l2 : l3;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// edge_rise: registered 1-bit rising-edge detector with async reset,
// reusable for any synchronous button input.
module edge_rise (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) d_q <= 1'b0;
        else       d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/shift_tick_gen.sv
// shift_tick_gen: advance strobe for the LED rotation shift register, either
// from a switch-selected prescaler (continuous) or one pulse per step press (idle).
module shift_tick_gen
    import shift_tick_pkg::*;
#(
    parameter int          NB_COUNTER = NB_COUNTER_DEF,
    parameter int          NB_SEL     = NB_SEL_DEF,
    parameter logic [63:0] LIMIT_R0   = 64'd1 << 20,
    parameter logic [63:0] LIMIT_R1   = 64'd1 << 22,
    parameter logic [63:0] LIMIT_R2   = 64'd1 << 24,
    parameter logic [63:0] LIMIT_R3   = 64'd1 << 26
) (
    input  logic              clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [NB_SEL-1:0] i_sel,
    input  logic              i_step,
    output logic              o_valid,
    output logic              o_running
);

    state_e                  state_q, state_d;
    logic [NB_COUNTER-1:0]   cnt_q, cnt_d;
    logic [NB_SEL-1:0]       sel_q;
    logic                    valid_q, valid_d;
    logic                    step_rise;
    logic [NB_COUNTER-1:0]   lim_m1;

    edge_rise u_step_edge (
        .clk_i  (clock),
        .rst_i  (i_reset),
        .d_i    (i_step),
        .rise_o (step_rise)
    );

    // Truncation to NB_COUNTER bits makes a 2**NB_COUNTER period wrap to all-ones.
    assign lim_m1 = NB_COUNTER'(sel_to_limit(2'(sel_q), LIMIT_R0, LIMIT_R1, LIMIT_R2, LIMIT_R3)
                                - 64'd1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        if (state_q == ST_IDLE) begin
            if (i_enable) begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end else begin
                valid_d = step_rise;
            end
        end else if (!i_enable) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (i_sel != sel_q) begin
            cnt_d   = '0;
        end else if (cnt_q == lim_m1) begin
            cnt_d   = '0;
            valid_d = 1'b1;
        end else begin
            cnt_d   = cnt_q + NB_COUNTER'(1);
        end
    end

    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= i_sel;
            valid_q <= valid_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_running = (state_q == ST_RUN);

endmodule

// File: tb/tb_shift_tick_gen.sv
// tb_shift_tick_gen: directed plan plus random traffic against a pulse-schedule
// model (anchor edge + period arithmetic) with limits 4/8/16/32.
module tb_shift_tick_gen;

    logic       clock = 1'b0;
    logic       i_reset, i_enable, i_step;
    logic [1:0] i_sel;
    logic       o_valid, o_running;

    int         checks = 0, errors = 0, n = 0, anchor = 0, pulses = 0;
    bit         run_m = 1'b0, prev_m = 1'b0;
    logic [1:0] sel_m = 2'd0;

    shift_tick_gen #(
        .NB_COUNTER (32),
        .NB_SEL     (2),
        .LIMIT_R0   (64'd4),
        .LIMIT_R1   (64'd8),
        .LIMIT_R2   (64'd16),
        .LIMIT_R3   (64'd32)
    ) dut (
        .clock     (clock),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_sel     (i_sel),
        .i_step    (i_step),
        .o_valid   (o_valid),
        .o_running (o_running)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int period(input logic [1:0] s);
        return 4 << s;
    endfunction

    // A pulse is due whenever a whole number of periods has elapsed since the anchor edge.
    task automatic tick(input string tag, input bit en, input logic [1:0] sel, input bit step);
        bit ev = 1'b0;
        i_enable = en;
        i_sel    = sel;
        i_step   = step;
        @(posedge clock);
        n++;
        if (!run_m) begin
            if (en) begin
                run_m  = 1'b1;
                anchor = n;
            end else if (step && !prev_m) ev = 1'b1;
        end else if (!en) run_m = 1'b0;
        else if (sel != sel_m) anchor = n;
        else if ((n - anchor) % period(sel_m) == 0) ev = 1'b1;
        sel_m  = sel;
        prev_m = step;
        #1;
        check({tag, "_valid"}, 32'(o_valid), 32'(ev));
        check({tag, "_run"}, 32'(o_running), 32'(run_m));
        if (o_valid) pulses++;
    endtask

    task automatic do_reset(input string tag);
        #1 i_reset = 1'b1;
        run_m  = 1'b0;
        sel_m  = 2'd0;
        prev_m = 1'b0;
        #1;
        check({tag, "_rst_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_rst_run"}, 32'(o_running), 32'd0);
        #1 i_reset = 1'b0;
    endtask

    initial begin
        bit         en = 1'b0;
        logic [1:0] sel = 2'd0;
        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_sel    = 2'd0;
        i_step   = 1'b0;
        #1;
        check("reset_valid", 32'(o_valid), 32'd0);
        check("reset_run", 32'(o_running), 32'd0);
        #2 i_reset = 1'b0;

        repeat (50) tick("t1", 0, 0, 0);

        repeat (21) tick("t2", 1, 0, 0);
        tick("t2", 0, 0, 0);

        repeat (21) tick("t3", 1, 3, 0);
        repeat (30) tick("t3", 1, 1, 0);
        tick("t3", 0, 1, 0);

        pulses = 0;
        repeat (10) tick("t4", 0, 1, 1);
        repeat (3) tick("t4", 0, 1, 0);
        repeat (4) tick("t4", 0, 1, 1);
        tick("t4", 0, 1, 0);
        check("t4_pulses", 32'(pulses), 32'd2);

        repeat (2) tick("t5", 0, 0, 0);
        repeat (9) tick("t5", 1, 0, 1);
        tick("t5", 0, 0, 0);

        repeat (10) tick("t6", 1, 2, 0);
        do_reset("t6");
        tick("t6", 0, 2, 0);
        repeat (20) tick("t6", 1, 2, 0);

        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 24) == 0) en = ~en;
            if ($urandom_range(0, 19) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset("rnd");
            tick("rnd", en, sel, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
